btn_bram_reader: RTL and testbench

//  Upstream front-end for the BRAM read path. Synchronises and debounces raw push-buttons and

---
 rtl/btn_reader_pkg.sv | 18 +
 rtl/btn_debounce.sv | 43 ++++
 rtl/btn_bram_reader.sv | 144 ++++++++++++++
 tb/tb_btn_bram_reader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/btn_reader_pkg.sv
// rtl/btn_reader_pkg.sv - shared types and helpers for the button-driven BRAM reader
package btn_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  // Depth of the per-button metastability synchroniser.
  localparam int SYNC_STAGES = 2;

  // Bits needed for a counter that runs 0 .. n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stability counter for one button
module btn_debounce
  import btn_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   level;

  assign level = sync[SYNC_STAGES-1];

  // Plain shift chain into the clock domain; nothing sits between the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], btn};
  end

  // Count consecutive cycles the synced level disagrees with db; accept it once the run is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (level == db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      db  <= level;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_bram_reader.sv
// rtl/btn_bram_reader.sv - debounced button press to one BRAM read, result on LEDs (option: BTN_AUTOREPEAT_EN)
module btn_bram_reader
  import btn_reader_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RD_LATENCY      = 2,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] leds,
  output logic [N_BTN-1:0]  btn_db,
  output logic              busy
);

  localparam int LW = cnt_width(RD_LATENCY);

  if ((2 ** ADDR_W) < N_BTN || RD_LATENCY < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("btn_bram_reader: illegal parameter combination");
  end

  logic [1:0]        rst_sync;
  logic              rst_i;
  logic [N_BTN-1:0]  db_prev;
  logic [N_BTN-1:0]  press;
  logic              press_any;
  logic              start;
  logic [ADDR_W-1:0] win_idx;
  logic [LW-1:0]     lat_cnt;
  state_t            state, state_nxt;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_i),
      .btn  (btn[g]),
      .db   (btn_db[g])
    );
  end

  // Previous debounced levels, for rising-edge press detection.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) db_prev <= '0;
    else        db_prev <= btn_db;
  end
  assign press     = btn_db & ~db_prev;
  assign press_any = |press;

  // Lowest pressed index wins; the scan runs high to low so the last hit is the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press[i]) win_idx = ADDR_W'(i);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_armed;
  logic          held;
  logic          rep_req;

  assign held    = rep_armed && (btn_db == (N_BTN'(1) << bram_addr));
  assign rep_req = held && (rep_cnt == REP_MAX);
  assign start   = press_any || rep_req;

  // Repeat timer restarts at each ISSUE and saturates, so a request made while busy waits for IDLE.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else begin
      if (press_any && state == IDLE) rep_armed <= 1'b1;
      else if (!held)                 rep_armed <= 1'b0;
      if (!held || press_any || state == ISSUE) rep_cnt <= '0;
      else if (rep_cnt != REP_MAX)              rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign start = press_any;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: one issue cycle, then wait out the BRAM latency.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bram_en = (state == ISSUE);
    busy    = (state != IDLE);
  end

  // Address capture, latency countdown and LED register.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      bram_addr <= '0;
      lat_cnt   <= '0;
      leds      <= '0;
    end else begin
      unique case (state)
        IDLE:    if (press_any) bram_addr <= win_idx;
        ISSUE:   lat_cnt <= LW'(RD_LATENCY - 1);
        WAIT: begin
          if (lat_cnt == '0) leds <= bram_dout;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_bram_reader.sv
// tb/tb_btn_bram_reader.sv - self-checking bench for btn_bram_reader with timeline model
module tb_btn_bram_reader;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn = 4'b0;
  logic       bram_en;
  logic [3:0] bram_addr;
  logic [3:0] bram_dout;
  logic [3:0] leds;
  logic [3:0] btn_db;
  logic       busy;

  int tests = 0;
  int fails = 0;

  btn_bram_reader #(
    .N_BTN(NB), .ADDR_W(4), .DATA_W(4),
    .DEBOUNCE_CYCLES(DB), .RD_LATENCY(RL), .REPEAT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .leds(leds), .btn_db(btn_db), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mem_word(input logic [3:0] a);
    return 4'(4'hA + a);
  endfunction

  // Two-cycle BRAM: address sampled with ena, data two clocks later.
  logic [3:0] r1 = 4'h0, r2 = 4'h0;
  always @(posedge clk) begin
    if (bram_en) r1 <= mem_word(bram_addr);
    r2 <= r1;
  end
  assign bram_dout = r2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: debounced levels, then a read timeline (issue edge t0, capture at t0+RL+1).
  int         rs_cnt = 0;
  int         e = 0;
  int         t0 = 0;
  int         run [NB];
  logic [3:0] h0 = 0, h1 = 0, m_db = 0, m_dbp = 0, m_leds = 0, m_addr = 0, press;
  logic       pend = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_cnt = 0; e = 0; pend = 0; h0 = 0; h1 = 0; m_db = 0; m_dbp = 0; m_leds = 0; m_addr = 0;
      for (int i = 0; i < NB; i++) run[i] = 0;
    end else begin
      if (rs_cnt >= 2) begin
        e++;
        press = m_db & ~m_dbp;
        if (pend && e == t0 + RL + 1) m_leds = mem_word(m_addr);
        if (press != 0 && !(pend && e - 1 >= t0 && e - 1 <= t0 + RL)) begin
          for (int i = NB - 1; i >= 0; i--) if (press[i]) m_addr = 4'(i);
          t0 = e;
          pend = 1;
        end
        m_dbp = m_db;
        for (int i = 0; i < NB; i++) begin
          if (h1[i] != m_db[i]) begin
            run[i]++;
            if (run[i] == DB) begin m_db[i] = h1[i]; run[i] = 0; end
          end else run[i] = 0;
        end
        h1 = h0;
        h0 = btn;
      end
      if (rs_cnt < 2) rs_cnt++;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    check("model_en",   32'(bram_en),   32'(pend && e == t0));
    check("model_busy", 32'(busy),      32'(pend && e >= t0 && e <= t0 + RL));
    check("model_addr", 32'(bram_addr), 32'(m_addr));
    check("model_leds", 32'(leds),      32'(m_leds));
    check("model_db",   32'(btn_db),    32'(m_db));
  end

  // Event monitor for the hand-computed expectations.
  int         cyc = 0;
  int         en_cnt = 0, en_cyc = 0, busy_cnt = 0, leds_cyc = 0, db_cyc = 0;
  logic [3:0] last_addr = 0, prev_leds = 0, db_or = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bram_en) begin en_cnt++; en_cyc = cyc; last_addr = bram_addr; end
    if (busy) busy_cnt++;
    if (leds != prev_leds) leds_cyc = cyc;
    prev_leds = leds;
    if (btn_db[2] && !db_or[2]) db_cyc = cyc;
    db_or = db_or | btn_db;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr;
    en_cnt = 0; busy_cnt = 0; db_or = 0;
  endtask

  int mark;

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    check("rst_leds", 32'(leds), 0);
    check("rst_addr", 32'(bram_addr), 0);
    check("rst_en",   32'(bram_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_db",   32'(btn_db), 0);
    rst_n = 1'b1;
    tick(4);

    // Single press of button 2.
    clr(); btn = 4'b0100; mark = cyc;
    tick(10); btn = 4'b0; tick(12);
    check("t2_db_delay", 32'(db_cyc - mark), 6);
    check("t2_en_cnt",   32'(en_cnt), 1);
    check("t2_addr",     32'(last_addr), 2);
    check("t2_leds",     32'(leds), 32'h0C);
    check("t2_latency",  32'(leds_cyc - en_cyc), 3);
    check("t2_busy_len", 32'(busy_cnt), 3);

    // Three-cycle glitch on button 1.
    clr(); btn = 4'b0010; tick(3); btn = 4'b0; tick(10);
    check("t3_db",     32'(db_or), 0);
    check("t3_en_cnt", 32'(en_cnt), 0);
    check("t3_leds",   32'(leds), 32'h0C);

    // Buttons 1 and 3 together.
    clr(); btn = 4'b1010; tick(10); btn = 4'b0; tick(12);
    check("t4_en_cnt", 32'(en_cnt), 1);
    check("t4_addr",   32'(last_addr), 1);
    check("t4_leds",   32'(leds), 32'h0B);
    check("t4_db_seen", 32'(db_or), 32'hA);

    // Button 3 pressed while the button 0 read is in flight.
    clr(); btn = 4'b0001; tick(2); btn = 4'b1001; tick(12); btn = 4'b0; tick(12);
    check("t5_en_cnt",  32'(en_cnt), 1);
    check("t5_addr",    32'(last_addr), 0);
    check("t5_leds",    32'(leds), 32'h0A);
    check("t5_db3_seen", 32'(db_or[3]), 1);

    // Reset during WAIT, then a fresh press of button 3.
    clr(); btn = 4'b0001;
    for (int k = 0; k < 30 && !(busy && !bram_en); k++) tick(1);
    check("t6_reach_wait", 32'(busy && !bram_en), 1);
    #2 rst_n = 1'b0; btn = 4'b0;
    #1;
    check("t6_async_leds", 32'(leds), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_addr", 32'(bram_addr), 0);
    tick(2); rst_n = 1'b1; tick(15);
    check("t6_no_capture", 32'(leds), 0);
    check("t6_en_cnt",     32'(en_cnt), 1);
    btn = 4'b1000; tick(10); btn = 4'b0; tick(12);
    check("t6_addr", 32'(last_addr), 3);
    check("t6_leds", 32'(leds), 32'h0D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
